// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer: PC, ROM handshake, IF/ID control
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall_req,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic        o_rom_req,
  output logic [31:0] o_rom_addr,
  input  logic        i_rom_ack,
  input  logic [31:0] i_rom_rdata,
  output logic        o_ifid_we,
  output logic        o_ifid_flush,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_inst,
  output logic [31:0] o_fetch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DISCARD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_hold_inst;
  logic [31:0] r_stale_addr;
  logic [31:0] r_fetch_cnt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_hold_nxt;
  logic [31:0] w_stale_nxt;
  logic        w_cnt_inc;
  logic [31:0] w_tgt;

  assign w_tgt       = i_br_target & 32'hFFFF_FFFC;
  assign o_fetch_cnt = r_fetch_cnt;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_hold_nxt   = r_hold_inst;
    w_stale_nxt  = r_stale_addr;
    w_cnt_inc    = 1'b0;
    o_rom_req    = 1'b0;
    o_rom_addr   = 32'h0;
    o_ifid_we    = 1'b0;
    o_ifid_flush = 1'b0;
    o_if_pc      = 32'h0;
    o_if_inst    = 32'h0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        if (i_br_taken) begin
          o_ifid_flush = 1'b1;
          w_pc_nxt     = w_tgt;
        end
      end
      S_FETCH: begin
        o_rom_req  = 1'b1;
        o_rom_addr = r_pc;
        if (i_br_taken) begin
          o_ifid_flush = 1'b1;
          w_pc_nxt     = w_tgt;
          // Unanswered request must still be completed, but its data is stale
          if (!i_rom_ack) begin
            w_state_nxt = S_DISCARD;
            w_stale_nxt = r_pc;
          end
        end else if (i_rom_ack) begin
          o_if_pc   = r_pc;
          o_if_inst = i_rom_rdata;
          if (i_stall_req) begin
            w_hold_nxt  = i_rom_rdata;
            w_state_nxt = S_HOLD;
          end else begin
            o_ifid_we = 1'b1;
            w_pc_nxt  = r_pc + 32'd4;
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (i_br_taken) begin
          o_ifid_flush = 1'b1;
          w_pc_nxt     = w_tgt;
          w_hold_nxt   = 32'h0;
          w_state_nxt  = S_FETCH;
        end else begin
          o_if_pc   = r_pc;
          o_if_inst = r_hold_inst;
          if (!i_stall_req) begin
            o_ifid_we   = 1'b1;
            w_pc_nxt    = r_pc + 32'd4;
            w_cnt_inc   = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DISCARD: begin
        o_rom_req  = 1'b1;
        o_rom_addr = r_stale_addr;
        if (i_br_taken) begin
          o_ifid_flush = 1'b1;
          w_pc_nxt     = w_tgt;
        end else if (i_rom_ack) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_hold_inst  <= 32'h0;
      r_stale_addr <= 32'h0;
      r_fetch_cnt  <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_hold_inst  <= w_hold_nxt;
      r_stale_addr <= w_stale_nxt;
      if (w_cnt_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - vector table, reset sequence and random model check for if_fetch_ctrl
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall_req;
  logic        br_taken;
  logic [31:0] br_target;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_rdata;
  logic        ifid_we;
  logic        ifid_flush;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] fetch_cnt;

  int unsigned vectors;
  int unsigned errors;

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_stall_req(stall_req), .i_br_taken(br_taken), .i_br_target(br_target),
    .o_rom_req(rom_req), .o_rom_addr(rom_addr),
    .i_rom_ack(rom_ack), .i_rom_rdata(rom_rdata),
    .o_ifid_we(ifid_we), .o_ifid_flush(ifid_flush),
    .o_if_pc(if_pc), .o_if_inst(if_inst), .o_fetch_cnt(fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we;
    logic        e_flush;
    logic        chk_data;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic a, logic [31:0] d,
                              logic rq, logic [31:0] ad, logic we, logic fl, logic cd,
                              logic [31:0] pc, logic [31:0] ins, logic [31:0] cnt);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.ack = a; v.rdata = d;
    v.e_req = rq; v.e_addr = ad; v.e_we = we; v.e_flush = fl; v.chk_data = cd;
    v.e_pc = pc; v.e_inst = ins; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  // Behavioural model state: what the fetch unit has promised so far
  logic        m_started, m_holding, m_stale_wait;
  logic [31:0] m_pc, m_held, m_stale, m_cnt;

  task automatic model_step(input logic s, input logic b, input logic [31:0] t,
                            input logic a, input logic [31:0] d);
    logic        e_req, deliver;
    logic [31:0] e_addr, e_inst;
    e_req   = m_started && !m_holding;
    e_addr  = m_stale_wait ? m_stale : m_pc;
    deliver = 1'b0;
    e_inst  = 32'h0;
    if (m_started && !b && !s) begin
      if (m_holding) begin deliver = 1'b1; e_inst = m_held; end
      else if (!m_stale_wait && a) begin deliver = 1'b1; e_inst = d; end
    end
    chk("rnd_req", {31'b0, rom_req}, {31'b0, e_req});
    if (e_req) chk("rnd_addr", rom_addr, e_addr);
    chk("rnd_we", {31'b0, ifid_we}, {31'b0, deliver});
    chk("rnd_flush", {31'b0, ifid_flush}, {31'b0, b});
    chk("rnd_cnt", fetch_cnt, m_cnt);
    if (deliver) begin
      chk("rnd_pc", if_pc, m_pc);
      chk("rnd_inst", if_inst, e_inst);
    end
    if (!m_started) begin
      m_started = 1'b1;
      if (b) m_pc = {t[31:2], 2'b00};
    end else if (b) begin
      if (m_holding) m_holding = 1'b0;
      else if (!m_stale_wait && !a) begin m_stale_wait = 1'b1; m_stale = m_pc; end
      m_pc = {t[31:2], 2'b00};
    end else if (deliver) begin
      m_holding = 1'b0;
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end else if (m_stale_wait) begin
      if (a) m_stale_wait = 1'b0;
    end else if (!m_holding && a && s) begin
      m_holding = 1'b1;
      m_held    = d;
    end
  endtask

  initial begin
    logic        rom_busy;
    int unsigned rom_lat, rom_wait;
    logic [31:0] rom_a;
    vectors = 0; errors = 0;
    rst_n = 1'b0; stall_req = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    rom_ack = 1'b0; rom_rdata = 32'h0;

    tbl.push_back(mk(0,0,32'h0,1,32'hDEAD_BEEF, 0,32'h0,0,0,1,32'h0,32'h0,32'd0));
    tbl.push_back(mk(0,0,32'h0,1,32'h1000_0000, 1,32'h0,1,0,1,32'h0,32'h1000_0000,32'd0));
    tbl.push_back(mk(0,0,32'h0,1,32'h1000_0001, 1,32'h4,1,0,1,32'h4,32'h1000_0001,32'd1));
    tbl.push_back(mk(1,0,32'h0,1,32'h2108_0001, 1,32'h8,0,0,0,32'h0,32'h0,32'd2));
    tbl.push_back(mk(1,0,32'h0,0,32'h0, 0,32'h0,0,0,1,32'h8,32'h2108_0001,32'd2));
    tbl.push_back(mk(1,0,32'h0,0,32'h0, 0,32'h0,0,0,1,32'h8,32'h2108_0001,32'd2));
    tbl.push_back(mk(0,0,32'h0,0,32'h0, 0,32'h0,1,0,1,32'h8,32'h2108_0001,32'd2));
    tbl.push_back(mk(0,0,32'h0,0,32'h0, 1,32'hC,0,0,0,32'h0,32'h0,32'd3));
    tbl.push_back(mk(0,0,32'h0,0,32'h0, 1,32'hC,0,0,0,32'h0,32'h0,32'd3));
    tbl.push_back(mk(0,0,32'h0,1,32'h1000_0003, 1,32'hC,1,0,1,32'hC,32'h1000_0003,32'd3));
    tbl.push_back(mk(0,1,32'h103,0,32'h0, 1,32'h10,0,1,0,32'h0,32'h0,32'd4));
    tbl.push_back(mk(0,0,32'h0,0,32'h0, 1,32'h10,0,0,0,32'h0,32'h0,32'd4));
    tbl.push_back(mk(0,0,32'h0,1,32'hBAD0_BAD0, 1,32'h10,0,0,0,32'h0,32'h0,32'd4));
    tbl.push_back(mk(0,0,32'h0,1,32'h1000_0004, 1,32'h100,1,0,1,32'h100,32'h1000_0004,32'd4));
    tbl.push_back(mk(1,0,32'h0,1,32'h1000_0005, 1,32'h104,0,0,0,32'h0,32'h0,32'd5));
    tbl.push_back(mk(1,1,32'h200,0,32'h0, 0,32'h0,0,1,0,32'h0,32'h0,32'd5));
    tbl.push_back(mk(0,0,32'h0,0,32'h0, 1,32'h200,0,0,0,32'h0,32'h0,32'd5));
    tbl.push_back(mk(0,0,32'h0,1,32'h1000_0006, 1,32'h200,1,0,1,32'h200,32'h1000_0006,32'd5));
    tbl.push_back(mk(0,1,32'hFFFF_FFFC,1,32'h5555_5555, 1,32'h204,0,1,0,32'h0,32'h0,32'd6));
    tbl.push_back(mk(0,0,32'h0,1,32'h1000_0007, 1,32'hFFFF_FFFC,1,0,1,32'hFFFF_FFFC,32'h1000_0007,32'd6));
    tbl.push_back(mk(0,0,32'h0,0,32'h0, 1,32'h0,0,0,0,32'h0,32'h0,32'd7));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (tbl[i]) begin
      stall_req = tbl[i].stall; br_taken = tbl[i].br; br_target = tbl[i].tgt;
      rom_ack = tbl[i].ack; rom_rdata = tbl[i].rdata;
      #2;
      chk($sformatf("t%0d_req", i), {31'b0, rom_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), rom_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_we", i), {31'b0, ifid_we}, {31'b0, tbl[i].e_we});
      chk($sformatf("t%0d_flush", i), {31'b0, ifid_flush}, {31'b0, tbl[i].e_flush});
      chk($sformatf("t%0d_cnt", i), fetch_cnt, tbl[i].e_cnt);
      if (tbl[i].chk_data) begin
        chk($sformatf("t%0d_pc", i), if_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_inst", i), if_inst, tbl[i].e_inst);
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a pending request
    stall_req = 1'b0; br_taken = 1'b0; rom_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, rom_req}, 32'h0);
    chk("arst_cnt", fetch_cnt, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("arst_idle_req", {31'b0, rom_req}, 32'h0);
    chk("arst_idle_we", {31'b0, ifid_we}, 32'h0);
    @(posedge clk);
    #3;
    chk("arst_fetch_req", {31'b0, rom_req}, 32'h1);
    chk("arst_fetch_addr", rom_addr, 32'h0);

    // Random traffic against the behavioural model
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_started = 1'b0; m_holding = 1'b0; m_stale_wait = 1'b0;
    m_pc = 32'h0; m_held = 32'h0; m_stale = 32'h0; m_cnt = 32'h0;
    rom_busy = 1'b0; rom_lat = 0; rom_wait = 0; rom_a = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      stall_req = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = $urandom;
      #1;
      if (rom_req) begin
        if (!rom_busy) begin
          rom_busy = 1'b1;
          rom_lat  = $urandom_range(0, 3);
          rom_wait = 0;
          rom_a    = rom_addr;
        end else begin
          chk("rom_addr_stable", rom_addr, rom_a);
        end
        rom_ack   = (rom_wait == rom_lat);
        rom_rdata = rom_word(rom_addr);
        if (rom_ack) rom_busy = 1'b0;
        else rom_wait++;
      end else begin
        rom_ack   = $urandom_range(0, 1) == 1;
        rom_rdata = $urandom;
      end
      #1;
      model_step(stall_req, br_taken, br_target, rom_ack, rom_rdata);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
